// File: rtl/spi_master_tx.sv
// spi_master_tx: 12-bit SPI transmit master, LSB first.
// Accepts a word via a ready/newd handshake, generates a free-running
// sync_clock from clk, drives CS/MOSI only on sync_clock falling edges so
// they are stable at every slave rising edge, and holds CS high for
// GAP_CYC sync_clock periods between frames so the slave can re-arm.
// Optional feature macro: SPI_TX_FRAME_CNT_EN adds a 16-bit frame counter.

module spi_master_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        newd,
    input  logic [11:0] din,
    output logic        ready,
    output logic        sync_clock,
    output logic        CS,
    output logic        MOSI,
    output logic        tx_done
`ifdef SPI_TX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic [11:0]      shreg;
    logic [2:0]       state;
    logic             toggle;
    logic             fall_ev;

    // The toggle cycle of sync_clock; when it is currently high this is the
    // cycle in which the slave's falling edge is produced.
    assign toggle  = (div_cnt == DIV_LAST);
    assign fall_ev = toggle && sync_clock;

    // Free-running divider: sync_clock toggles every CLK_DIV clk cycles in all states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            sync_clock <= 1'b0;
        end else if (toggle) begin
            div_cnt    <= '0;
            sync_clock <= ~sync_clock;
        end else begin
            div_cnt    <= div_cnt + 1'b1;
        end
    end

    // Frame sequencer: every CS/MOSI update happens on a fall_ev cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            ready   <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (newd && ready) begin
                        shreg <= din;
                        ready <= 1'b0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (fall_ev) begin
                        CS    <= 1'b0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (fall_ev) begin
                        MOSI    <= shreg[0];
                        shreg   <= {1'b0, shreg[11:1]};
                        bit_cnt <= 4'd1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_ev) begin
                        if (bit_cnt == 4'd12) begin
                            CS      <= 1'b1;
                            MOSI    <= 1'b0;
                            tx_done <= 1'b1;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            MOSI    <= shreg[0];
                            shreg   <= {1'b0, shreg[11:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (fall_ev) begin
                        if (gap_cnt == GAP_LAST) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    CS    <= 1'b1;
                    MOSI  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPI_TX_FRAME_CNT_EN
    // Completed-frame counter; wraps naturally, aborted frames never pulse tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tx_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: scoreboard bench for spi_master_tx.
// Two instances run side by side: one with CLK_DIV=4/GAP_CYC=2 and one with
// CLK_DIV=1/GAP_CYC=1. Accepted words are pushed into per-instance queues;
// a clk-sampled monitor reassembles each frame the way a slave would and
// pops/compares on every CS rising edge.

module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rst_n0 = 1'b0;
    logic        rst_n1 = 1'b0;
    logic        newd0 = 1'b0;
    logic        newd1 = 1'b0;
    logic [11:0] din0 = '0;
    logic [11:0] din1 = '0;
    logic        ready0, ready1;
    logic        sclk0, sclk1;
    logic        cs0, cs1;
    logic        mosi0, mosi1;
    logic        txd0, txd1;
`ifdef SPI_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt0, frame_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    int          frames_exp[2];
    int          tx_cnt[2];
    int          tx_since_rst[2];

    spi_master_tx #(.CLK_DIV(4), .GAP_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n0), .newd(newd0), .din(din0), .ready(ready0),
        .sync_clock(sclk0), .CS(cs0), .MOSI(mosi0), .tx_done(txd0)
`ifdef SPI_TX_FRAME_CNT_EN
        , .frame_cnt(frame_cnt0)
`endif
    );

    spi_master_tx #(.CLK_DIV(1), .GAP_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .newd(newd1), .din(din1), .ready(ready1),
        .sync_clock(sclk1), .CS(cs1), .MOSI(mosi1), .tx_done(txd1)
`ifdef SPI_TX_FRAME_CNT_EN
        , .frame_cnt(frame_cnt1)
`endif
    );

    // System clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic checkTrue(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int divOf(input int idx);
        return (idx == 0) ? 4 : 1;
    endfunction

    function automatic int gapOf(input int idx);
        return (idx == 0) ? 2 : 1;
    endfunction

    function automatic logic readyOf(input int idx);
        return (idx == 0) ? ready0 : ready1;
    endfunction

    function automatic logic csOf(input int idx);
        return (idx == 0) ? cs0 : cs1;
    endfunction

    task automatic setNewd(input int idx, input logic v, input logic [11:0] w);
        if (idx == 0) begin
            newd0 = v;
            din0  = w;
        end else begin
            newd1 = v;
            din1  = w;
        end
    endtask

    // Bounded wait until the instance can accept a word.
    task automatic waitReady(input int idx);
        int n = 0;
        @(negedge clk);
        while (readyOf(idx) !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkTrue($sformatf("ready_timeout%0d", idx), n < 5000, n, 5000);
    endtask

    // Offer one word; with hold_early the newd request is raised while the
    // master is still busy and kept high until the handshake completes.
    task automatic applyStimulus(input int idx, input logic [11:0] w, input bit hold_early);
        int n = 0;
        if (hold_early) setNewd(idx, 1'b1, w);
        waitReady(idx);
        setNewd(idx, 1'b1, w);
        @(posedge clk);
        if (idx == 0) exp_q0.push_back(w);
        else          exp_q1.push_back(w);
        frames_exp[idx]++;
        #1;
        setNewd(idx, 1'b0, $urandom_range(0, 4095));
        checkOutput($sformatf("ready_drop%0d", idx), readyOf(idx), 0);
        while (n < 2 * divOf(idx) + 4) begin
            @(posedge clk);
            n++;
            #1;
            if (csOf(idx) == 1'b0) break;
        end
        checkTrue($sformatf("cs_latency%0d", idx),
                  n >= 1 && n <= 2 * divOf(idx) && csOf(idx) == 1'b0, n, 2 * divOf(idx));
    endtask

    // Slave-side view of both buses, sampled on the clk falling edge.
    logic [12:0] sh[2];
    int          nrise[2], low_cnt[2], high_cnt[2], rdy_cnt[2];
    bit          have_end[2], rdy_arm[2];
    logic        ps[2], pc[2], pm[2], pt[2], pr[2];

    always @(negedge clk) begin
        logic s[2], c[2], m[2], t[2], r[2], rn[2];
        logic [11:0] want;
        s[0] = sclk0;  c[0] = cs0;  m[0] = mosi0;  t[0] = txd0;  r[0] = ready0; rn[0] = rst_n0;
        s[1] = sclk1;  c[1] = cs1;  m[1] = mosi1;  t[1] = txd1;  r[1] = ready1; rn[1] = rst_n1;
        for (int i = 0; i < 2; i++) begin
            if (rn[i] !== 1'b1) begin
                have_end[i]     = 1'b0;
                rdy_arm[i]      = 1'b0;
                nrise[i]        = 0;
                tx_since_rst[i] = 0;
            end else begin
                if ((m[i] !== pm[i]) || (c[i] !== pc[i]))
                    checkTrue($sformatf("edge_align%0d", i), !s[i] && ps[i], s[i], 0);
                if (s[i] && !ps[i] && c[i] == 1'b0) begin
                    sh[i] = {m[i], sh[i][12:1]};
                    nrise[i]++;
                end
                if (c[i] && !pc[i]) begin
                    checkOutput($sformatf("cs_low_clks%0d", i), low_cnt[i], 26 * divOf(i));
                    checkOutput($sformatf("rise_count%0d", i), nrise[i], 13);
                    if (i == 0 && exp_q0.size() > 0)      want = exp_q0.pop_front();
                    else if (i == 1 && exp_q1.size() > 0) want = exp_q1.pop_front();
                    else begin
                        want = 'x;
                        checkTrue($sformatf("unexpected_frame%0d", i), 1'b0, 1, 0);
                    end
                    if (!$isunknown(want))
                        checkOutput($sformatf("slave_word%0d", i), sh[i][12:1], want);
                    have_end[i] = 1'b1;
                    high_cnt[i] = 0;
                end
                if (!c[i] && pc[i]) begin
                    if (have_end[i])
                        checkTrue($sformatf("cs_gap%0d", i),
                                  high_cnt[i] >= 2 * divOf(i) * gapOf(i),
                                  high_cnt[i], 2 * divOf(i) * gapOf(i));
                    low_cnt[i] = 0;
                    nrise[i]   = 0;
                end
                if (c[i]) high_cnt[i]++;
                else      low_cnt[i]++;
                if (t[i]) begin
                    checkTrue($sformatf("tx_done_width%0d", i), !pt[i], 2, 1);
                    tx_cnt[i]++;
                    tx_since_rst[i]++;
                    rdy_arm[i] = 1'b1;
                    rdy_cnt[i] = 0;
                end else if (rdy_arm[i]) begin
                    rdy_cnt[i]++;
                    if (r[i] && !pr[i]) begin
                        checkOutput($sformatf("ready_rise_clks%0d", i), rdy_cnt[i],
                                    2 * divOf(i) * gapOf(i));
                        rdy_arm[i] = 1'b0;
                    end
                end
            end
            ps[i] = s[i]; pc[i] = c[i]; pm[i] = m[i]; pt[i] = t[i]; pr[i] = r[i];
        end
    end

    task automatic resetChecks(input int idx);
        if (idx == 0) begin
            checkOutput("rst_cs0", cs0, 1);
            checkOutput("rst_sclk0", sclk0, 0);
            checkOutput("rst_mosi0", mosi0, 0);
            checkOutput("rst_ready0", ready0, 1);
            checkOutput("rst_txdone0", txd0, 0);
        end else begin
            checkOutput("rst_cs1", cs1, 1);
            checkOutput("rst_sclk1", sclk1, 0);
            checkOutput("rst_ready1", ready1, 1);
        end
    endtask

    // Directed plus random traffic on the CLK_DIV=4 instance.
    task automatic seq0();
        int n;
        repeat (3) @(posedge clk);
        #1 resetChecks(0);
        @(negedge clk) rst_n0 = 1'b1;

        applyStimulus(0, 12'hA5C, 1'b0);
        applyStimulus(0, 12'h001, 1'b0);
        applyStimulus(0, 12'h800, 1'b1);

        // A request while busy must be dropped and must not raise ready.
        applyStimulus(0, 12'hFFF, 1'b0);
        repeat (40) @(negedge clk);
        newd0 = 1'b1;
        din0  = 12'h123;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput("busy_ready0", ready0, 0);
        end
        newd0 = 1'b0;

        // Abort a 12'h555 frame while bit 6 is on the wire.
        applyStimulus(0, 12'h555, 1'b0);
        n = 0;
        while (n < 7) begin
            @(posedge sclk0 or negedge cs0);
            if (cs0 == 1'b0 && sclk0 == 1'b1) n++;
        end
        repeat (2) @(negedge clk);
        rst_n0 = 1'b0;
        #1 resetChecks(0);
        exp_q0.delete();
        frames_exp[0]--;
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1;

        applyStimulus(0, 12'h0F0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            applyStimulus(0, 12'($urandom_range(0, 4095)), k[0]);
        end
        waitReady(0);
    endtask

    // Fastest-divider instance: boundary data values then random words.
    task automatic seq1();
        repeat (2) @(posedge clk);
        #1 resetChecks(1);
        @(negedge clk) rst_n1 = 1'b1;
        applyStimulus(1, 12'h000, 1'b0);
        applyStimulus(1, 12'hFFF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            applyStimulus(1, 12'($urandom_range(0, 4095)), 1'b0);
        end
        waitReady(1);
    endtask

    // Run both sequences, then reconcile frame totals and print the summary.
    initial begin
        frames_exp   = '{0, 0};
        tx_cnt       = '{0, 0};
        tx_since_rst = '{0, 0};
        fork
            seq0();
            seq1();
        join
        repeat (4) @(negedge clk);
        checkOutput("tx_done_total0", tx_cnt[0], frames_exp[0]);
        checkOutput("tx_done_total1", tx_cnt[1], frames_exp[1]);
        checkOutput("queue_left0", exp_q0.size(), 0);
        checkOutput("queue_left1", exp_q1.size(), 0);
`ifdef SPI_TX_FRAME_CNT_EN
        checkOutput("frame_cnt0", frame_cnt0, tx_since_rst[0] & 16'hFFFF);
        checkOutput("frame_cnt1", frame_cnt1, tx_since_rst[1] & 16'hFFFF);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=%0d required=%0d", 1, 0);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Upstream SPI master for the 12-bit SPI slave. It accepts a 12-bit word from the system side through a ready/valid (newd) handshake and divides the system clock to produce the free-running sync_clock. It drives CS and MOSI, LSB first, so the slave's right-shift register reassembles the word unchanged. It also enforces the inter-frame CS-high gap that the slave needs to re-arm.

Parameters:
CLK_DIV, 4, sync_clock half-period in clk cycles (legal range ≥1)
GAP_CYC, 2, number of full sync_clock periods that CS is held high after a frame (legal range ≥1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
newd  input  1  word valid; sampled on clk when ready=1
din  input  12  word to transmit; captured with newd
ready  output  1  high when a new word can be accepted
sync_clock  output  1  serial clock to slave; free-running
CS  output  1  chip select, active low
MOSI  output  1  serial data, LSB first
tx_done  output  1  one-clk pulse when a frame completes

Behaviour:
- Reset (async, rst_n=0) forces the following; everything is released on the next clk after rst_n rises:
  - sync_clock=0, CS=1, MOSI=0, ready=1, tx_done=0
  - div_cnt=0, bit_cnt=0, shreg=0, state=IDLE
- Divider and sync_clock:
  - div_cnt counts 0..CLK_DIV-1 on every clk, wraps, and toggles sync_clock at CLK_DIV-1.
  - rise_ev: toggle while sync_clock=0. fall_ev: toggle while sync_clock=1.
  - sync_clock runs in every state, never gated.
- CS and MOSI change only on the clk cycle of a fall_ev, so both are stable across every slave posedge.
- FSM, states IDLE, ARM, SETUP, SHIFT, GAP:
  - IDLE: ready=1, CS=1, MOSI=0. newd&&ready → shreg<=din, ready<=0, go to ARM.
  - ARM: on fall_ev → CS<=0, go to SETUP. The slave sees CS=0 at the next rise (R0).
  - SETUP: on fall_ev → MOSI<=shreg[0], shreg>>=1, bit_cnt<=1, go to SHIFT.
  - SHIFT: on fall_ev with bit_cnt<12 → MOSI<=shreg[0], shift, bit_cnt++. Bits 0..11 are sampled at slave rises R1..R12.
  - SHIFT: on fall_ev with bit_cnt==12 → CS<=1, MOSI<=0, tx_done=1 for one clk, go to GAP.
  - GAP: counts GAP_CYC fall_ev, then goes to IDLE with ready<=1. This guarantees the slave sees CS=1 when it re-enters its start state (R14).
- Frame timing: CS is low for exactly 13 sync_clock periods. Total frame is 13+GAP_CYC periods plus ARM alignment.
- Latency: newd → CS low is 1..2*CLK_DIV clk cycles, depending on divider phase.
- newd while ready=0 is ignored; the word is not queued and there is no error flag. din is irrelevant when ready=0.
- newd on the same clk that ready rises (GAP→IDLE) is not accepted; acceptance starts on the next clk.
- Reset mid-frame aborts immediately: CS=1 asynchronously, and the partial word is discarded.
- Data values 12'h000 and 12'hFFF carry no special case.

Optional Feature:
SPI_TX_FRAME_CNT_EN
- Defined: adds output frame_cnt[15:0].
  - Reset value 0.
  - Increments on every tx_done pulse and wraps 16'hFFFF→0.
  - Not incremented by frames aborted by reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- CLK_DIV=4, newd with din=12'hA5C → MOSI bits at R1..R12 = 0,0,1,1,1,0,1,0,0,1,0,1; CS low for 13 sync_clock periods; one tx_done; slave dout=12'hA5C and slave done=1.
- Back-to-back words 12'h001 then 12'h800, second newd held until ready=1 → slave outputs 12'h001 then 12'h800; CS high for ≥GAP_CYC periods between frames; 2 tx_done pulses.
- newd with din=12'h123 asserted during the SHIFT of a 12'hFFF frame → only 12'hFFF is transmitted; ready stays 0 until GAP ends; no extra CS frame.
- rst_n=0 at bit 6 of a 12'h555 frame → CS=1, sync_clock=0, ready=1 within the same clk; no tx_done. The next word 12'h0F0 transmits correctly after reset.
- CLK_DIV=1, GAP_CYC=1, din=12'h000 then 12'hFFF → slave dout 12'h000 then 12'hFFF; MOSI never changes on a rise_ev.
- SPI_TX_FRAME_CNT_EN defined, 3 frames → frame_cnt=3. Forced to 16'hFFFF, one more frame → frame_cnt=0.
